// File: rtl/sm_result_bcd_decoder_pkg.sv
// Shared types and constants for the sign-magnitude result BCD decoder.
package sm_result_bcd_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam int unsigned BCD_W          = 4;
  localparam int unsigned ADD3_THRESHOLD = 5;
  localparam logic [BCD_W-1:0] BLANK_CODE = 4'hF;

endpackage

// File: rtl/sm_result_bcd_decoder_bcd_add3_cell.sv
// One double-dabble digit correction: add 3 when the digit is 5 or more.
module bcd_add3_cell
  import sm_result_bcd_decoder_pkg::*;
(
  input  logic [BCD_W-1:0] digit,
  output logic [BCD_W-1:0] adjusted_c
);

  always_comb begin
    adjusted_c = digit;
    if (digit >= BCD_W'(ADD3_THRESHOLD)) adjusted_c = digit + BCD_W'(3);
  end

endmodule

// File: rtl/sm_result_bcd_decoder.sv
// Sign-magnitude result to BCD decoder using one double-dabble step per cycle.
// Optional leading-zero blanking is enabled by defining SM_BCD_LEADING_BLANK_EN.
module sm_result_bcd_decoder
  import sm_result_bcd_decoder_pkg::*;
#(
  parameter int unsigned MAG_W  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [MAG_W:0]            in_result,
  input  logic                      in_div_by_zero,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_neg,
  output logic                      out_err,
  output logic [BCD_W*DIGITS-1:0]   out_bcd
);

  localparam int unsigned BCD_TW = BCD_W * DIGITS;
  localparam int unsigned CNT_W  = (MAG_W > 1) ? $clog2(MAG_W) : 1;

`ifdef SM_BCD_LEADING_BLANK_EN
  localparam logic [BCD_TW-1:0] ERR_BCD = {DIGITS{BLANK_CODE}};
`else
  localparam logic [BCD_TW-1:0] ERR_BCD = '0;
`endif

  state_t            state;
  logic [MAG_W-1:0]  shift_q;
  logic [BCD_TW-1:0] bcd_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              neg_q;

  logic [BCD_TW-1:0] adj_c;
  logic [BCD_TW-1:0] next_bcd_c;
  logic [MAG_W-1:0]  next_shift_c;
  logic [BCD_TW-1:0] disp_bcd_c;

  for (genvar d = 0; d < DIGITS; d++) begin : g_add3
    bcd_add3_cell u_cell (
      .digit      (bcd_q[d*BCD_W +: BCD_W]),
      .adjusted_c (adj_c[d*BCD_W +: BCD_W])
    );
  end

  // Shift the corrected accumulator and the magnitude left together.
  assign next_bcd_c   = {adj_c[BCD_TW-2:0], shift_q[MAG_W-1]};
  assign next_shift_c = {shift_q[MAG_W-2:0], 1'b0};

`ifdef SM_BCD_LEADING_BLANK_EN
  // Blank zero digits above the first non-zero one; ones digit always shown.
  always_comb begin
    logic seen;
    disp_bcd_c = next_bcd_c;
    seen       = 1'b0;
    for (int d = DIGITS - 1; d >= 1; d--) begin
      if (next_bcd_c[d*BCD_W +: BCD_W] != '0) seen = 1'b1;
      if (!seen) disp_bcd_c[d*BCD_W +: BCD_W] = BLANK_CODE;
    end
  end
`else
  assign disp_bcd_c = next_bcd_c;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_neg   <= 1'b0;
      out_err   <= 1'b0;
      out_bcd   <= '0;
      shift_q   <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (in_div_by_zero) begin
              out_err   <= 1'b1;
              out_neg   <= 1'b0;
              out_bcd   <= ERR_BCD;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              shift_q <= in_result[MAG_W-1:0];
              bcd_q   <= '0;
              cnt_q   <= '0;
              // Negative zero is displayed as +0.
              neg_q   <= in_result[MAG_W] & (|in_result[MAG_W-1:0]);
              state   <= CONVERT;
            end
          end
        end
        CONVERT: begin
          bcd_q   <= next_bcd_c;
          shift_q <= next_shift_c;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(MAG_W - 1)) begin
            out_bcd   <= disp_bcd_c;
            out_neg   <= neg_q;
            out_err   <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sm_result_bcd_decoder.sv
// Self-checking bench for sm_result_bcd_decoder: directed table, corner sequences, random words.
module tb_sm_result_bcd_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [8:0]  in_result;
  logic        in_div_by_zero;
  logic        out_valid;
  logic        out_ready;
  logic        out_neg;
  logic        out_err;
  logic [11:0] out_bcd;

  int checks = 0;
  int errors = 0;

  sm_result_bcd_decoder dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_result      (in_result),
    .in_div_by_zero (in_div_by_zero),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_neg        (out_neg),
    .out_err        (out_err),
    .out_bcd        (out_bcd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]  word;
    logic        div0;
    logic        neg;
    logic        err;
    logic [11:0] bcd;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: decimal digits by plain arithmetic, blanking applied afterwards.
  function automatic logic [11:0] model_bcd(input logic [7:0] mag, input logic err);
    int h, t, o;
    logic [3:0] hd, td, od;
    h = int'(mag) / 100;
    t = (int'(mag) / 10) % 10;
    o = int'(mag) % 10;
    hd = 4'(h);
    td = 4'(t);
    od = 4'(o);
`ifdef SM_BCD_LEADING_BLANK_EN
    if (err) return 12'hFFF;
    if (h == 0) hd = 4'hF;
    if (h == 0 && t == 0) td = 4'hF;
`else
    if (err) return 12'h000;
`endif
    return {hd, td, od};
  endfunction

  // One full transaction: accept, wait for result, optional backpressure, release.
  task automatic run_txn(input string tag, input logic [8:0] word, input logic div0,
                         input logic exp_neg, input logic exp_err, input logic [11:0] exp_bcd,
                         input int hold);
    int lat;
    chk({tag, " in_ready before accept"}, 32'(in_ready), 32'd1);
    in_valid       = 1'b1;
    in_result      = word;
    in_div_by_zero = div0;
    step();
    in_valid       = 1'b0;
    in_div_by_zero = 1'b0;
    chk({tag, " in_ready after accept"}, 32'(in_ready), 32'd0);
    lat = 1;
    while (!out_valid && lat < 30) begin
      step();
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), div0 ? 32'd1 : 32'd9);
    chk({tag, " out_neg"}, 32'(out_neg), 32'(exp_neg));
    chk({tag, " out_err"}, 32'(out_err), 32'(exp_err));
    chk({tag, " out_bcd"}, 32'(out_bcd), 32'(exp_bcd));
    out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      in_valid  = 1'b1;
      in_result = 9'(32'($urandom));
      step();
      chk({tag, " hold out_valid"}, 32'(out_valid), 32'd1);
      chk({tag, " hold in_ready"}, 32'(in_ready), 32'd0);
      chk({tag, " hold out_bcd"}, 32'(out_bcd), 32'(exp_bcd));
      chk({tag, " hold out_neg"}, 32'(out_neg), 32'(exp_neg));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, " release out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, " release in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    vec_t vecs[8];
    rst            = 1'b1;
    in_valid       = 1'b0;
    in_result      = '0;
    in_div_by_zero = 1'b0;
    out_ready      = 1'b0;

`ifdef SM_BCD_LEADING_BLANK_EN
    vecs[0] = '{9'h0FF, 1'b0, 1'b0, 1'b0, 12'h255};
    vecs[1] = '{9'h107, 1'b0, 1'b1, 1'b0, 12'hFF7};
    vecs[2] = '{9'h100, 1'b0, 1'b0, 1'b0, 12'hFF0};
    vecs[3] = '{9'h000, 1'b0, 1'b0, 1'b0, 12'hFF0};
    vecs[4] = '{9'h1AB, 1'b1, 1'b0, 1'b1, 12'hFFF};
    vecs[5] = '{9'h140, 1'b0, 1'b1, 1'b0, 12'hF64};
    vecs[6] = '{9'h164, 1'b0, 1'b1, 1'b0, 12'h100};
    vecs[7] = '{9'h063, 1'b0, 1'b0, 1'b0, 12'hF99};
`else
    vecs[0] = '{9'h0FF, 1'b0, 1'b0, 1'b0, 12'h255};
    vecs[1] = '{9'h107, 1'b0, 1'b1, 1'b0, 12'h007};
    vecs[2] = '{9'h100, 1'b0, 1'b0, 1'b0, 12'h000};
    vecs[3] = '{9'h000, 1'b0, 1'b0, 1'b0, 12'h000};
    vecs[4] = '{9'h1AB, 1'b1, 1'b0, 1'b1, 12'h000};
    vecs[5] = '{9'h140, 1'b0, 1'b1, 1'b0, 12'h064};
    vecs[6] = '{9'h164, 1'b0, 1'b1, 1'b0, 12'h100};
    vecs[7] = '{9'h063, 1'b0, 1'b0, 1'b0, 12'h099};
`endif

    step();
    step();
    rst = 1'b0;
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_neg", 32'(out_neg), 32'd0);
    chk("reset out_err", 32'(out_err), 32'd0);
    chk("reset out_bcd", 32'(out_bcd), 32'd0);

    for (int i = 0; i < 8; i++)
      run_txn($sformatf("vec%0d", i), vecs[i].word, vecs[i].div0,
              vecs[i].neg, vecs[i].err, vecs[i].bcd, 0);

    // Long backpressure in DONE, with a competing word offered throughout.
    run_txn("backpressure", 9'h0FF, 1'b0, 1'b0, 1'b0, model_bcd(8'hFF, 1'b0), 20);
    run_txn("after_bp", 9'h10A, 1'b0, 1'b1, 1'b0, model_bcd(8'h0A, 1'b0), 0);

    // Reset on the fourth CONVERT cycle discards the conversion.
    in_valid       = 1'b1;
    in_result      = 9'h080;
    in_div_by_zero = 1'b0;
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst in_ready", 32'(in_ready), 32'd1);
    chk("midrst out_valid", 32'(out_valid), 32'd0);
    chk("midrst out_bcd", 32'(out_bcd), 32'd0);
    chk("midrst out_neg", 32'(out_neg), 32'd0);
    step();
    chk("midrst idle out_valid", 32'(out_valid), 32'd0);
    run_txn("post_rst", 9'h140, 1'b0, 1'b1, 1'b0, model_bcd(8'h40, 1'b0), 0);

    // Random words against the arithmetic reference.
    for (int n = 0; n < 40; n++) begin
      logic [8:0] w;
      logic       d0;
      logic       en;
      w  = 9'($urandom_range(0, 511));
      d0 = ($urandom_range(0, 7) == 0);
      en = w[8] && (w[7:0] != 8'd0) && !d0;
      run_txn($sformatf("rnd%0d", n), w, d0, en, d0, model_bcd(w[7:0], d0),
              int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
